// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the request-side queue in front of the 3-way
// round-robin arbiter: requester count, index width, the one-hot grant
// vector type and a decoder that turns a grant vector into an index plus a
// "exactly one bit set" flag.
// ---------------------------------------------------------------------------
package rr_pkg;

  localparam int NREQ_C = 3;
  localparam int IDX_W  = 2;

  // One-hot grant vector as driven by the arbiter; all-zero means no grant.
  typedef logic [NREQ_C-1:0] gnt_vec_t;

  // Decoded grant: index of the set bit and whether exactly one bit is set.
  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } gnt_dec_t;

  // Returns the index of the highest set bit and legal = 1 only when the
  // vector is exactly one-hot. idx is meaningless when legal = 0.
  function automatic gnt_dec_t onehot_to_idx(input gnt_vec_t gnt);
    gnt_dec_t res;
    int       ones;
    res.legal = 1'b0;
    res.idx   = '0;
    ones      = 0;
    for (int i = 0; i < NREQ_C; i++) begin
      if (gnt[i]) begin
        ones    = ones + 1;
        res.idx = IDX_W'(i);
      end
    end
    res.legal = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/rr_req_fifo.sv
// ---------------------------------------------------------------------------
// rr_req_fifo
// Single-requester FIFO. Pointers are log2(DEPTH) bits and wrap naturally;
// the occupancy counter is one bit wider so it can represent 0..DEPTH.
// A push while full and a pop while empty are both ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; empties the FIFO
//   push       write push_data (ignored when full)
//   push_data  payload to write
//   pop        discard the head entry (ignored when empty)
//   head_data  oldest entry, valid while !empty
//   full       count == DEPTH
//   empty      count == 0
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module rr_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic              push_en, pop_en;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;  // idle, or push and pop together
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rr_req_queue.sv
// ---------------------------------------------------------------------------
// rr_req_queue
// Request-side buffering stage in front of the 3-way round-robin arbiter.
// One FIFO per requester; each FIFO's non-empty flag forms the request
// vector. A legal one-hot grant pops the granted FIFO into a single output
// register with a valid/ready handshake, tagged with the source index.
//
// Optional build macro: RR_REQ_QUEUE_GNT_CHECK_EN
//   defined   - gnt_err is set (sticky until reset) the edge after any
//               non-zero grant that is multi-hot or targets an empty FIFO.
//   undefined - gnt_err is tied to 0 and no checking logic exists.
// Illegal grants never pop in either build.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; discards all buffered/output data
//   in_valid   per-requester push strobe
//   in_data    per-requester payload, slice i = in_data[i*DATA_W +: DATA_W]
//   in_ready   per-requester FIFO not full
//   req_out    per-requester FIFO non-empty (request vector to arbiter)
//   gnt_in     one-hot grant from arbiter, 0 = no grant
//   out_valid  output register holds a payload
//   out_ready  downstream accepts the payload
//   out_data   popped payload
//   out_src    requester index that supplied out_data
//   gnt_err    sticky illegal-grant flag
// ---------------------------------------------------------------------------
module rr_req_queue
  import rr_pkg::*;
#(
  parameter int NREQ   = NREQ_C,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        in_valid,
  input  logic [NREQ*DATA_W-1:0] in_data,
  output logic [NREQ-1:0]        in_ready,
  output logic [NREQ-1:0]        req_out,
  input  logic [NREQ-1:0]        gnt_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_src,
  output logic                   gnt_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] fifo_head  [NREQ];
  logic [PTR_W:0]    fifo_count [NREQ];
  logic [NREQ-1:0]   fifo_full;
  logic [NREQ-1:0]   fifo_empty;
  logic [NREQ-1:0]   fifo_pop;

  gnt_dec_t          gnt_dec;
  logic [NREQ-1:0]   gnt_hit;     // granted FIFOs that actually hold data
  logic              slot_free;
  logic              pop_ok;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]  out_src_q,   out_src_d;

  // ---------------------------------------------------------------------
  // Per-requester FIFOs
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    rr_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (fifo_pop[g]),
      .head_data (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .count     (fifo_count[g])
    );

    // Both flags come straight from the registered count, so a FIFO that is
    // pushed for the first time requests only from the following cycle.
    assign in_ready[g] = !fifo_full[g];
    assign req_out[g]  = (fifo_count[g] != '0);
  end

  // ---------------------------------------------------------------------
  // Grant decode
  // ---------------------------------------------------------------------
  assign gnt_dec   = onehot_to_idx(gnt_vec_t'(gnt_in));
  assign gnt_hit   = gnt_in & ~fifo_empty;
  assign slot_free = !out_valid_q || out_ready;

  // A pop needs an exactly one-hot grant on a non-empty FIFO and room in the
  // output register. Under back-pressure a legal grant is simply dropped;
  // the arbiter keeps seeing the request and re-grants later.
  assign pop_ok   = gnt_dec.legal && (gnt_hit != '0) && slot_free;
  assign fifo_pop = gnt_hit & {NREQ{pop_ok}};

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_head[gnt_dec.idx];
      out_src_d   = gnt_dec.idx;
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it: payload and tag keep their value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // ---------------------------------------------------------------------
  // Illegal-grant flag
  // ---------------------------------------------------------------------
`ifdef RR_REQ_QUEUE_GNT_CHECK_EN
  logic gnt_err_q, gnt_err_d;
  logic gnt_illegal;

  // Any non-zero grant that is multi-hot or lands on an empty FIFO. This is
  // independent of back-pressure: a legal grant that is merely ignored for
  // lack of output space is not an error.
  assign gnt_illegal = (gnt_in != '0) && !(gnt_dec.legal && (gnt_hit != '0));
  assign gnt_err_d   = gnt_err_q || gnt_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gnt_err_q <= 1'b0;
    else       gnt_err_q <= gnt_err_d;
  end

  assign gnt_err = gnt_err_q;
`else
  assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
// ---------------------------------------------------------------------------
// tb_rr_req_queue
// Directed scenarios plus a randomized run of rr_req_queue. The reference
// model keeps one queue per requester and a single output slot, updated from
// the documented push/pop/drain rules once per clock.
// ---------------------------------------------------------------------------
module tb_rr_req_queue;
  import rr_pkg::*;

  localparam int NREQ   = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

`ifdef RR_REQ_QUEUE_GNT_CHECK_EN
  localparam bit GNT_CHECK = 1'b1;
`else
  localparam bit GNT_CHECK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        in_valid = '0;
  logic [NREQ*DATA_W-1:0] in_data = '0;
  logic [NREQ-1:0]        in_ready;
  logic [NREQ-1:0]        req_out;
  logic [NREQ-1:0]        gnt_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DATA_W-1:0]      out_data;
  logic [IDX_W-1:0]       out_src;
  logic                   gnt_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [NREQ][$];
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_src;
  bit                m_err;

  rr_req_queue #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req_out   (req_out),
    .gnt_in    (gnt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .gnt_err   (gnt_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------
  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_err   = 1'b0;
  endtask

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [NREQ-1:0] exp_req();
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  // Apply the current inputs to the model, then advance one clock and land
  // 1 time unit after the rising edge where outputs are stable.
  task automatic step();
    int              ones;
    int              gi;
    bit              slot;
    bit              hit;
    logic [NREQ-1:0] fullv;
    ones = 0;
    gi   = 0;
    for (int i = 0; i < NREQ; i++) begin
      fullv[i] = (mq[i].size() == DEPTH);
      if (gnt_in[i]) begin
        ones = ones + 1;
        gi   = i;
      end
    end
    slot = !m_valid || out_ready;
    hit  = (ones == 1) && (mq[gi].size() != 0);
    if (gnt_in != '0 && !hit) m_err = 1'b1;
    if (hit && slot) begin
      m_data  = mq[gi].pop_front();
      m_src   = IDX_W'(gi);
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NREQ; i++)
      if (in_valid[i] && !fullv[i]) mq[i].push_back(in_data[i*DATA_W +: DATA_W]);
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int idx, input logic [DATA_W-1:0] val);
    in_valid           = '0;
    in_valid[idx]      = 1'b1;
    in_data[idx*DATA_W +: DATA_W] = val;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (in_ready !== 3'b111) begin bad++; $display("FAIL reset_in_ready: got %b want 111", in_ready); end
    total++; if (req_out !== 3'b000) begin bad++; $display("FAIL reset_req_out: got %b want 000", req_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00 || out_src !== 2'd0) begin bad++; $display("FAIL reset_out_regs: got %h/%0d want 00/0", out_data, out_src); end
    total++; if (gnt_err !== 1'b0) begin bad++; $display("FAIL reset_gnt_err: got %b want 0", gnt_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    out_ready = 1'b1;
    step();
    step();
    total++; if (in_ready !== 3'b111 || req_out !== 3'b000 || out_valid !== 1'b0 || gnt_err !== 1'b0) begin
      bad++; $display("FAIL idle: got rdy=%b req=%b vld=%b err=%b", in_ready, req_out, out_valid, gnt_err);
    end
  endtask

  task automatic test_single_path();
    set_push(1, 8'hA5);
    step();
    in_valid = '0;
    total++; if (req_out !== 3'b010) begin bad++; $display("FAIL single_req: got %b want 010", req_out); end
    gnt_in = 3'b010;
    step();
    gnt_in = '0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd1) begin
      bad++; $display("FAIL single_out: got v=%b d=%h s=%0d want 1/a5/1", out_valid, out_data, out_src);
    end
    total++; if (req_out !== 3'b000) begin bad++; $display("FAIL single_req_after_pop: got %b want 000", req_out); end
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      bad++; $display("FAIL single_drain: got v=%b d=%h want 0/a5", out_valid, out_data);
    end
  endtask

  task automatic test_full_wrap();
    logic [DATA_W-1:0] order [6];
    order = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int k = 0; k < 4; k++) begin
      set_push(0, order[k]);
      step();
    end
    in_valid = '0;
    total++; if (in_ready !== 3'b110) begin bad++; $display("FAIL full_in_ready: got %b want 110", in_ready); end
    gnt_in = 3'b001;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== order[k] || out_src !== 2'd0) begin
        bad++; $display("FAIL wrap_pop%0d: got v=%b d=%h s=%0d want 1/%h/0", k, out_valid, out_data, out_src, order[k]);
      end
    end
    gnt_in = '0;
    for (int k = 4; k < 6; k++) begin
      set_push(0, order[k]);
      step();
    end
    in_valid = '0;
    total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL wrap_full_again: got %b want 0", in_ready[0]); end
    gnt_in = 3'b001;
    for (int k = 2; k < 6; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== order[k]) begin
        bad++; $display("FAIL wrap_pop%0d: got v=%b d=%h want 1/%h", k, out_valid, out_data, order[k]);
      end
    end
    gnt_in = '0;
    total++; if (req_out[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL wrap_empty: got req=%b rdy=%b want 0/1", req_out[0], in_ready[0]);
    end
    step();
  endtask

  task automatic test_back_pressure();
    in_valid = 3'b110;
    in_data[1*DATA_W +: DATA_W] = 8'h11;
    in_data[2*DATA_W +: DATA_W] = 8'h3C;
    step();
    in_valid  = '0;
    gnt_in    = 3'b010;
    out_ready = 1'b0;
    step();
    gnt_in = 3'b100;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd1 || req_out !== 3'b100) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d req=%b want 1/11/1/100", k, out_valid, out_data, out_src, req_out);
      end
    end
    out_ready = 1'b1;
    step();
    gnt_in = '0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 2'd2 || req_out !== 3'b000) begin
      bad++; $display("FAIL bp_release: got v=%b d=%h s=%0d req=%b want 1/3c/2/000", out_valid, out_data, out_src, req_out);
    end
    step();
  endtask

  task automatic test_concurrent();
    set_push(0, 8'hA1);
    step();
    set_push(0, 8'hA2);
    step();
    set_push(0, 8'hA3);
    gnt_in = 3'b001;
    step();
    in_valid = '0;
    total++; if (out_data !== 8'hA1 || req_out[0] !== 1'b1) begin
      bad++; $display("FAIL conc_first: got d=%h req=%b want a1/1", out_data, req_out[0]);
    end
    step();
    total++; if (out_data !== 8'hA2) begin bad++; $display("FAIL conc_second: got %h want a2", out_data); end
    step();
    gnt_in = '0;
    total++; if (out_data !== 8'hA3 || req_out[0] !== 1'b0) begin
      bad++; $display("FAIL conc_third: got d=%h req=%b want a3/0", out_data, req_out[0]);
    end
    step();
  endtask

  task automatic test_illegal_grant();
    set_push(1, 8'h77);
    step();
    in_valid = '0;
    gnt_in   = 3'b011;
    step();
    total++; if (out_valid !== 1'b0 || req_out !== 3'b010) begin
      bad++; $display("FAIL ill_multi_nopop: got v=%b req=%b want 0/010", out_valid, req_out);
    end
    total++; if (gnt_err !== GNT_CHECK) begin bad++; $display("FAIL ill_multi_err: got %b want %b", gnt_err, GNT_CHECK); end
    gnt_in = '0;
    step();
    step();
    total++; if (gnt_err !== GNT_CHECK) begin bad++; $display("FAIL ill_sticky: got %b want %b", gnt_err, GNT_CHECK); end
    gnt_in = 3'b001;
    step();
    total++; if (out_valid !== 1'b0 || gnt_err !== GNT_CHECK) begin
      bad++; $display("FAIL ill_empty: got v=%b err=%b want 0/%b", out_valid, gnt_err, GNT_CHECK);
    end
    gnt_in = 3'b010;
    step();
    gnt_in = '0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_src !== 2'd1) begin
      bad++; $display("FAIL ill_then_legal: got v=%b d=%h s=%0d want 1/77/1", out_valid, out_data, out_src);
    end
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 3'b101;
    in_data[0*DATA_W +: DATA_W] = 8'hC0;
    in_data[2*DATA_W +: DATA_W] = 8'hC2;
    step();
    step();
    in_valid  = '0;
    out_ready = 1'b0;
    gnt_in    = 3'b100;
    step();
    gnt_in = '0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || req_out !== 3'b000 || in_ready !== 3'b111 || gnt_err !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got v=%b d=%h req=%b rdy=%b err=%b", out_valid, out_data, req_out, in_ready, gnt_err);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    model_clear();
    step();
  endtask

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        in_valid[i] = ($urandom_range(0, 1) == 1) && (mq[i].size() < DEPTH);
        in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 6)      gnt_in = NREQ'(1 << $urandom_range(0, NREQ - 1));
      else if (r < 8) gnt_in = '0;
      else            gnt_in = NREQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_ready()); end
      total++; if (req_out !== exp_req()) begin bad++; $display("FAIL rnd_req_out c%0d: got %b want %b", cyc, req_out, exp_req()); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, out_valid, m_valid); end
      total++; if (out_data !== m_data || out_src !== m_src) begin
        bad++; $display("FAIL rnd_out c%0d: got %h/%0d want %h/%0d", cyc, out_data, out_src, m_data, m_src);
      end
      total++; if (gnt_err !== (GNT_CHECK && m_err)) begin
        bad++; $display("FAIL rnd_gnt_err c%0d: got %b want %b", cyc, gnt_err, GNT_CHECK && m_err);
      end
    end
    in_valid = '0;
    gnt_in   = '0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_path();
    test_full_wrap();
    test_back_pressure();
    test_concurrent();
    test_illegal_grant();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
